// File: rtl/mips_pkg.sv
// Shared definitions for the ID-stage pipeline control blocks.
//   TAM_DIREC_REG : register address width
//   TAM_CONT      : default stall counter width
//   state_t       : debug control state encoding (RUN / HALT / STEP)
package mips_pkg;

   localparam int TAM_DIREC_REG = 5;
   localparam int TAM_CONT      = 16;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STEP = 2'd2
   } state_t;

endpackage

// File: rtl/reg_match.sv
// Destination-vs-source register comparator.
//   rd      : destination register of an older, in-flight instruction
//   rs, rt  : source registers of the instruction in ID
//   uses_rt : rt is a real source and must take part in the compare
//   hit     : rd is non-zero and equals rs, or equals rt when uses_rt is set
module reg_match #(
   parameter int W = 5
) (
   input  logic [W-1:0] rd,
   input  logic [W-1:0] rs,
   input  logic [W-1:0] rt,
   input  logic         uses_rt,
   output logic         hit
);

   // r0 is hardwired to zero, so writes to it never create a dependency
   assign hit = (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller with debug halt/step and a stall-cycle counter.
//   Inputs : ID source regs (rs/rt/uses_rt/branch), ID/EX and EX/MEM destination
//            and load flags, branch_taken, debug halt/step, counter clear.
//   Outputs: PC and IF/ID hold, ID/EX bubble, IF/ID flush, debug freeze,
//            step_done pulse, halted status, saturating stall counter.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   RUN   | normal operation, hazard controls active
//   HALT  | debug halt, every pipeline register frozen
//   STEP  | one cycle of execution released from HALT
module hazard_detection_unit
   import mips_pkg::state_t;
   import mips_pkg::RUN;
   import mips_pkg::HALT;
   import mips_pkg::STEP;
#(
   parameter int TAM_DIREC_REG = mips_pkg::TAM_DIREC_REG,
   parameter int TAM_CONT      = mips_pkg::TAM_CONT
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [TAM_DIREC_REG-1:0] i_rs_if_id,
   input  logic [TAM_DIREC_REG-1:0] i_rt_if_id,
   input  logic                     i_uses_rt,
   input  logic                     i_branch_id,
   input  logic [TAM_DIREC_REG-1:0] i_rd_id_ex,
   input  logic                     i_mem_read_id_ex,
   input  logic [TAM_DIREC_REG-1:0] i_rd_ex_mem,
   input  logic                     i_mem_read_ex_mem,
   input  logic                     i_branch_taken,
   input  logic                     i_halt,
   input  logic                     i_step,
   input  logic                     i_clr_count,
   output logic                     o_stall_pc,
   output logic                     o_stall_if_id,
   output logic                     o_flush_id_ex,
   output logic                     o_flush_if_id,
   output logic                     o_freeze,
   output logic                     o_step_done,
   output logic                     o_halted,
   output logic [TAM_CONT-1:0]      o_stall_count
);

   state_t              state_q, state_d;
   logic [TAM_CONT-1:0] count_q;
   logic                step_done_q;

   logic hit_lu, hit_idex_any, hit_exmem_any;
   logic lu, lb1, lb2, hz, active;

   reg_match #(.W(TAM_DIREC_REG)) u_match_lu (
      .rd(i_rd_id_ex), .rs(i_rs_if_id), .rt(i_rt_if_id),
      .uses_rt(i_uses_rt), .hit(hit_lu)
   );

   // Branches compare in ID, so both operands are always live sources
   reg_match #(.W(TAM_DIREC_REG)) u_match_idex (
      .rd(i_rd_id_ex), .rs(i_rs_if_id), .rt(i_rt_if_id),
      .uses_rt(1'b1), .hit(hit_idex_any)
   );

   reg_match #(.W(TAM_DIREC_REG)) u_match_exmem (
      .rd(i_rd_ex_mem), .rs(i_rs_if_id), .rt(i_rt_if_id),
      .uses_rt(1'b1), .hit(hit_exmem_any)
   );

   // A load feeding a branch stalls twice: once in ID/EX (lb2), then again in
   // EX/MEM (lb1) as the bubble pushes it forward, with no dedicated counter.
   assign lu  = i_mem_read_id_ex && hit_lu;
   assign lb2 = i_branch_id && i_mem_read_id_ex && hit_idex_any;
   assign lb1 = i_branch_id && i_mem_read_ex_mem && hit_exmem_any;
   assign hz  = lu || lb1 || lb2;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (i_halt) state_d = HALT;
         HALT:    if (!i_halt) state_d = RUN;
                  else if (i_step) state_d = STEP;
         STEP:    state_d = i_halt ? HALT : RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= RUN;
         step_done_q <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         step_done_q <= (state_q == STEP);
         if (i_clr_count)
            count_q <= '0;
         else if (hz && (state_q != HALT) && (count_q != '1))
            count_q <= count_q + TAM_CONT'(1);
      end
   end

   assign active        = !i_rst && (state_q != HALT);
   assign o_stall_pc    = active && hz;
   assign o_stall_if_id = active && hz;
   assign o_flush_id_ex = active && hz;
   // A stalled branch has not resolved yet, so its taken flag must not flush
   assign o_flush_if_id = active && i_branch_taken && !hz;
   assign o_freeze      = !i_rst && (state_q == HALT);
   assign o_halted      = !i_rst && (state_q == HALT);
   assign o_step_done   = step_done_q;
   assign o_stall_count = count_q;

endmodule
